// File: rtl/cdc_fifo_unpacker_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_fifo_unpacker_if
//  Description : Bundle of the FIFO peek/dequeue signals and the narrow
//                valid/ready chunk stream handled by cdc_fifo_unpacker.
//                master : the unpacker (consumes FIFO words, drives chunks)
//                slave  : the environment (FIFO peek side + stream sink)
//  Signals     : DataValid_In, DataIn  - FIFO peek word and its valid
//                Deq                   - dequeue pulse back to the FIFO
//                OutValid, OutReady    - chunk stream handshake
//                OutData, OutLast      - chunk payload, last-of-word flag
//                WordCount             - words dequeued, modulo 2^16
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdc_fifo_unpacker_if #(
    parameter int DataWidth = 32,
    parameter int OutWidth  = 8
);
    logic                 DataValid_In;
    logic [DataWidth-1:0] DataIn;
    logic                 Deq;
    logic                 OutValid;
    logic                 OutReady;
    logic [OutWidth-1:0]  OutData;
    logic                 OutLast;
    logic [15:0]          WordCount;

    modport master (
        input  DataValid_In, DataIn, OutReady,
        output Deq, OutValid, OutData, OutLast, WordCount
    );

    modport slave (
        output DataValid_In, DataIn, OutReady,
        input  Deq, OutValid, OutData, OutLast, WordCount
    );
endinterface
`default_nettype wire

// File: rtl/cdc_fifo_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : cdc_fifo_unpacker
//  Description : Receiver-domain consumer of the CDC FIFO peek/dequeue port.
//                Each FIFO word is split into DataWidth/OutWidth chunks and
//                emitted on a valid/ready stream, LSB- or MSB-chunk first.
//                The next word is loaded on the same edge that accepts the
//                last chunk, so a continuously ready sink sees no bubbles.
//  Ports       : clk  - receiver clock
//                rst  - asynchronous active-high reset
//                bus  - cdc_fifo_unpacker_if.master (FIFO peek + chunk stream)
//  Revision    : 1.0 - initial release
// ============================================================================
module cdc_fifo_unpacker #(
    parameter int DataWidth = 32,
    parameter int OutWidth  = 8,
    parameter int LsbFirst  = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    cdc_fifo_unpacker_if.master  bus
);
    localparam int c_N     = DataWidth / OutWidth;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N - 1);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [DataWidth-1:0] r_heldWord;
    logic [c_IDX_W-1:0]   r_chunkIdx;
    logic [15:0]          r_wordCount;

    logic                 w_valid;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_deq;
    logic [c_IDX_W-1:0]   w_sel;
    logic [OutWidth-1:0]  w_outData;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and handshake outputs. Deq is gated by rst so the FIFO is
    // never popped while this block is held in reset.
    always_comb begin
        w_valid     = (r_state == DRAIN);
        w_last      = w_valid && (r_chunkIdx == c_LAST_IDX);
        w_accept    = w_valid && bus.OutReady;
        w_deq       = !rst && bus.DataValid_In &&
                      ((r_state == EMPTY) || (w_accept && w_last));
        w_nextState = r_state;
        if (w_deq) begin
            // A load on the last-chunk accept keeps the stream in DRAIN.
            w_nextState = DRAIN;
        end else if (w_accept && w_last) begin
            w_nextState = EMPTY;
        end
    end

    // Held word, chunk index and dequeue counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_heldWord  <= '0;
            r_chunkIdx  <= '0;
            r_wordCount <= '0;
        end else if (w_deq) begin
            r_heldWord  <= bus.DataIn;
            r_chunkIdx  <= '0;
            r_wordCount <= r_wordCount + 16'd1;
        end else if (w_accept && !w_last) begin
            r_chunkIdx  <= r_chunkIdx + c_IDX_W'(1);
        end
    end

    // Physical chunk position: MSB-first walks the word from the top down.
    always_comb begin
        if (LsbFirst != 0) begin
            w_sel = r_chunkIdx;
        end else begin
            w_sel = c_LAST_IDX - r_chunkIdx;
        end
    end

    always_comb begin
        w_outData = '0;
        for (int i = 0; i < c_N; i++) begin
            if (w_sel == c_IDX_W'(i)) begin
                w_outData = r_heldWord[i*OutWidth +: OutWidth];
            end
        end
    end

    assign bus.Deq       = w_deq;
    assign bus.OutValid  = w_valid;
    assign bus.OutLast   = w_last;
    assign bus.OutData   = w_outData;
    assign bus.WordCount = r_wordCount;

endmodule
`default_nettype wire

// File: tb/tb_cdc_fifo_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdc_fifo_unpacker
//  Description : Self-checking bench for cdc_fifo_unpacker. Two 32->8
//                instances (LSB-first and MSB-first) share one stimulus;
//                a 32->32 instance runs long enough to wrap WordCount.
//                Expected outputs come from a queue-based stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_fifo_unpacker;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus for the 32->8 pair
    logic        rst   = 1'b1;
    logic        dv    = 1'b0;
    logic [31:0] din   = 32'h0;
    logic        ready = 1'b0;
    logic        kRst = 1'b1, kReady = 1'b1, kSrcEn = 1'b1;
    logic [31:0] srcQ[$];

    // Stimulus for the 32->32 instance
    logic        rst3 = 1'b1, dv3 = 1'b0, r3 = 1'b0;
    logic [31:0] d3   = 32'h0;
    logic        wrapMode = 1'b0;

    int nChecks = 0;
    int nErrors = 0;

    cdc_fifo_unpacker_if #(.DataWidth(32), .OutWidth(8))  ifL ();
    cdc_fifo_unpacker_if #(.DataWidth(32), .OutWidth(8))  ifM ();
    cdc_fifo_unpacker_if #(.DataWidth(32), .OutWidth(32)) if3 ();

    assign ifL.DataValid_In = dv;  assign ifL.DataIn = din; assign ifL.OutReady = ready;
    assign ifM.DataValid_In = dv;  assign ifM.DataIn = din; assign ifM.OutReady = ready;
    assign if3.DataValid_In = dv3; assign if3.DataIn = d3;  assign if3.OutReady = r3;

    cdc_fifo_unpacker #(.DataWidth(32), .OutWidth(8),  .LsbFirst(1)) dutL (.clk(clk), .rst(rst),  .bus(ifL));
    cdc_fifo_unpacker #(.DataWidth(32), .OutWidth(8),  .LsbFirst(0)) dutM (.clk(clk), .rst(rst),  .bus(ifM));
    cdc_fifo_unpacker #(.DataWidth(32), .OutWidth(32), .LsbFirst(1)) dut3 (.clk(clk), .rst(rst3), .bus(if3));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending chunks of the held word as {last, data}.
    // ------------------------------------------------------------------
    logic [8:0]  qL[$];
    logic [8:0]  qM[$];
    logic [15:0] cnt = 16'h0;
    logic [31:0] q3[$];
    logic [15:0] cnt3 = 16'h0;
    int          total3 = 0;

    always @(negedge clk) begin
        int   sz;
        logic ev, ed;
        if (rst) begin
            check("rst_deq",   32'(ifL.Deq),       32'd0);
            check("rst_valid", 32'(ifL.OutValid),  32'd0);
            check("rst_data",  32'(ifL.OutData),   32'd0);
            check("rst_last",  32'(ifL.OutLast),   32'd0);
            check("rst_count", 32'(ifL.WordCount), 32'd0);
            check("rst_validM",32'(ifM.OutValid),  32'd0);
            qL.delete(); qM.delete(); cnt = 16'h0;
        end else begin
            sz = qL.size();
            ev = (sz > 0);
            ed = dv && ((sz == 0) || ((sz == 1) && ready));
            check("valid",  32'(ifL.OutValid),  32'(ev));
            check("validM", 32'(ifM.OutValid),  32'(ev));
            check("deq",    32'(ifL.Deq),       32'(ed));
            check("deqM",   32'(ifM.Deq),       32'(ed));
            check("count",  32'(ifL.WordCount), 32'(cnt));
            if (ev) begin
                check("data",  32'(ifL.OutData), 32'(qL[0][7:0]));
                check("last",  32'(ifL.OutLast), 32'(qL[0][8]));
                check("dataM", 32'(ifM.OutData), 32'(qM[0][7:0]));
                check("lastM", 32'(ifM.OutLast), 32'(qM[0][8]));
                if (ready) begin
                    void'(qL.pop_front());
                    void'(qM.pop_front());
                end
            end
            if (ed) begin
                void'(srcQ.pop_front());
                cnt = cnt + 16'd1;
                for (int i = 0; i < N; i++) begin
                    qL.push_back({i == N-1, din[8*i +: 8]});
                    qM.push_back({i == N-1, din[8*(N-1-i) +: 8]});
                end
            end
        end

        if (rst3) begin
            check("rst3_deq",   32'(if3.Deq),       32'd0);
            check("rst3_valid", 32'(if3.OutValid),  32'd0);
            check("rst3_count", 32'(if3.WordCount), 32'd0);
            q3.delete(); cnt3 = 16'h0; total3 = 0;
        end else begin
            ev = (q3.size() > 0);
            ed = dv3 && (!ev || r3);
            check("valid3", 32'(if3.OutValid),  32'(ev));
            check("deq3",   32'(if3.Deq),       32'(ed));
            check("count3", 32'(if3.WordCount), 32'(cnt3));
            if (ev) begin
                check("data3", if3.OutData,       q3[0]);
                check("last3", 32'(if3.OutLast),  32'd1);
                if (r3) void'(q3.pop_front());
            end
            if (ed) begin
                q3.push_back(d3);
                cnt3 = cnt3 + 16'd1;
                total3++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver for the 32->32 instance
    // ------------------------------------------------------------------
    initial begin
        repeat (2) @(posedge clk);
        forever begin
            @(posedge clk); #1;
            rst3 = 1'b0;
            dv3  = wrapMode ? 1'b1 : ($urandom_range(0, 7) != 0);
            r3   = wrapMode ? 1'b1 : ($urandom_range(0, 7) != 0);
            d3   = $urandom;
        end
    end

    // One cycle: apply knobs 1 time unit after the edge, settle for another.
    task automatic cyc();
        @(posedge clk); #1;
        rst   = kRst;
        ready = kReady;
        dv    = kSrcEn && (srcQ.size() > 0);
        din   = dv ? srcQ[0] : 32'h0;
        #1;
    endtask

    logic [7:0] lsbExp[4];
    logic [7:0] msbExp[4];
    logic [7:0] bpExp[4];
    logic       reached;

    initial begin
        lsbExp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        msbExp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        bpExp  = '{8'h44, 8'h33, 8'h22, 8'h11};

        // Reset held with a word waiting
        srcQ.push_back(32'hA1B2C3D4);
        repeat (3) begin
            cyc();
            check("hold_rst_deq",   32'(ifL.Deq),       32'd0);
            check("hold_rst_valid", 32'(ifL.OutValid),  32'd0);
            check("hold_rst_data",  32'(ifL.OutData),   32'd0);
            check("hold_rst_last",  32'(ifL.OutLast),   32'd0);
            check("hold_rst_count", 32'(ifL.WordCount), 32'd0);
        end
        kRst = 1'b0;
        cyc();
        check("first_deq", 32'(ifL.Deq), 32'd1);

        // Single word, both chunk orders
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("single_data",  32'(ifL.OutData), 32'(lsbExp[i]));
            check("single_last",  32'(ifL.OutLast), 32'(i == 3));
            check("single_deq",   32'(ifL.Deq),     32'd0);
            check("msb_data",     32'(ifM.OutData), 32'(msbExp[i]));
            check("msb_last",     32'(ifM.OutLast), 32'(i == 3));
        end
        check("single_count", 32'(ifL.WordCount), 32'd1);

        // Back-to-back words, no bubble
        srcQ.push_back(32'h03020100);
        srcQ.push_back(32'h07060504);
        cyc();
        check("b2b_deq0",   32'(ifL.Deq),      32'd1);
        check("b2b_valid0", 32'(ifL.OutValid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("b2b_valid", 32'(ifL.OutValid), 32'd1);
            check("b2b_data",  32'(ifL.OutData),  32'(i));
            check("b2b_deq",   32'(ifL.Deq),      32'(i == 3));
            check("b2b_last",  32'(ifL.OutLast),  32'((i == 3) || (i == 7)));
        end
        check("b2b_count", 32'(ifL.WordCount), 32'd3);

        // Backpressure on chunk B2 with the next word already valid
        srcQ.push_back(32'hA1B2C3D4);
        srcQ.push_back(32'h11223344);
        cyc(); check("bp_deq0", 32'(ifL.Deq), 32'd1);
        cyc(); check("bp_d4",   32'(ifL.OutData), 32'hD4);
        cyc(); check("bp_c3",   32'(ifL.OutData), 32'hC3);
        kReady = 1'b0;
        repeat (5) begin
            cyc();
            check("bp_hold_data",  32'(ifL.OutData),  32'hB2);
            check("bp_hold_valid", 32'(ifL.OutValid), 32'd1);
            check("bp_hold_deq",   32'(ifL.Deq),      32'd0);
        end
        kReady = 1'b1;
        cyc(); check("bp_b2", 32'(ifL.OutData), 32'hB2);
        cyc();
        check("bp_a1",     32'(ifL.OutData), 32'hA1);
        check("bp_a1_deq", 32'(ifL.Deq),     32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("bp_next", 32'(ifL.OutData), 32'(bpExp[i]));
        end

        // Reset in the middle of a word
        srcQ.push_back(32'hA1B2C3D4);
        cyc(); check("mid_deq", 32'(ifL.Deq),     32'd1);
        cyc(); check("mid_d4",  32'(ifL.OutData), 32'hD4);
        cyc(); check("mid_c3",  32'(ifL.OutData), 32'hC3);
        kRst = 1'b1;
        cyc();
        check("mid_rst_valid", 32'(ifL.OutValid), 32'd0);
        check("mid_rst_data",  32'(ifL.OutData),  32'd0);
        kRst = 1'b0;
        repeat (3) begin
            cyc();
            check("mid_after_valid", 32'(ifL.OutValid), 32'd0);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ((srcQ.size() < 6) && ($urandom_range(0, 2) == 0)) srcQ.push_back($urandom);
            kReady = ($urandom_range(0, 3) != 0);
            kSrcEn = ($urandom_range(0, 7) != 0);
            kRst   = ($urandom_range(0, 299) == 0);
            cyc();
        end
        kRst = 1'b0;
        kSrcEn = 1'b1;
        kReady = 1'b1;

        // WordCount wrap on the single-chunk instance
        wrapMode = 1'b1;
        reached  = 1'b0;
        for (int k = 0; k < 80000; k++) begin
            @(negedge clk); #1;
            if (total3 >= 65536) begin
                reached = 1'b1;
                break;
            end
        end
        check("wrap_reached", 32'(reached), 32'd1);
        if (reached) begin
            @(posedge clk); #2;
            check("wrap_count", 32'(if3.WordCount), 32'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
`default_nettype wire
